// File: rtl/ddr_user_pkg.sv
// Shared definitions for the DDR user-port sequencers (read and write paths).
package ddr_user_pkg;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        HOLD,
        BDONE,
        WAIT,
        RETRY
    } rd_state_t;

endpackage

// File: rtl/ddr_read_controller_beat_packer.sv
// Pairs 32-bit DDR read beats into 64-bit words {odd, even} with a saturating beat count.
module beat_packer #(
    parameter int BEATS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    output logic        full_o
);

    localparam int CNT_W = $clog2(BEATS) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      low_q;
    logic [63:0]      data_q;
    logic             vld_q;
    logic             take;

    assign full_o  = (cnt_q == CNT_W'(BEATS));
    assign take    = en_i && valid_i && !full_o;
    assign data_o  = data_q;
    assign valid_o = vld_q;

    // The count LSB is the even/odd toggle; beats past BEATS are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            low_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (take) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!cnt_q[0]) begin
                    low_q <= data_i;
                end else begin
                    data_q <= {data_i, low_q};
                    vld_q  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_read_controller.sv
// Read-side DDR user-port sequencer: issues READ, times Burst_Done, packs beats,
// and re-issues a read that auto-refresh interrupted.
module ddr_read_controller
    import ddr_user_pkg::*;
#(
    parameter int ADDR_W  = 26,
    parameter int BEATS   = 4,
    parameter int CMD_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK_in,
    input  logic              RST_in,
    input  logic              Init_done,
    input  logic              Read_req_in,
    input  logic [ADDR_W-1:0] Addr_in,
    output logic [ADDR_W-1:0] Addr_out,
    output logic [2:0]        CMD_out,
    input  logic              CMD_ack,
    output logic              Burst_Done_out,
    input  logic              ar_req,
    input  logic              ar_done,
    input  logic              Data_valid_in,
    input  logic [31:0]       Data_in,
    output logic [63:0]       Data_out,
    output logic              Data_out_valid,
    output logic              Busy_out,
    output logic              Err_out
);

    localparam int TMO_W = $clog2(TIMEOUT + 1) + 1;
    localparam int HC_W  = $clog2(CMD_CYC + 1) + 1;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              bd_q, bd_d;
    logic              err_q, err_d;
    logic              ar_pend_q, ar_pend_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic              bdc_q, bdc_d;
    logic              accept;
    logic              cap_en;
    logic              full;

    assign cap_en = (state_q == HOLD) || (state_q == BDONE) || (state_q == WAIT);

    beat_packer #(.BEATS(BEATS)) u_packer (
        .clk_i   (CLK_in),
        .rst_i   (RST_in),
        .clr_i   (accept),
        .en_i    (cap_en),
        .valid_i (Data_valid_in),
        .data_i  (Data_in),
        .data_o  (Data_out),
        .valid_o (Data_out_valid),
        .full_o  (full)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        bdc_d   = 1'b0;
        accept  = 1'b0;
        // ar_done wins when both strobes land together.
        ar_pend_d = ar_done ? 1'b0 : (ar_req ? 1'b1 : ar_pend_q);

        case (state_q)
            IDLE: begin
                if (Read_req_in && Init_done && !ar_pend_q) begin
                    accept  = 1'b1;
                    addr_d  = Addr_in;
                    err_d   = 1'b0;
                    tmo_d   = TMO_W'(1);
                    state_d = CMD;
                end
            end
            CMD: begin
                if (CMD_ack) begin
                    hold_d  = HC_W'(1);
                    state_d = (CMD_CYC <= 1) ? BDONE : HOLD;
                end else if (ar_pend_q) begin
                    state_d = RETRY;
                end
            end
            HOLD: begin
                if (hold_q >= HC_W'(CMD_CYC - 1)) state_d = BDONE;
                else                              hold_d  = hold_q + HC_W'(1);
            end
            BDONE: begin
                if (bdc_q) state_d = full ? IDLE : WAIT;
                else       bdc_d   = 1'b1;
            end
            WAIT: begin
                if (full) state_d = IDLE;
            end
            RETRY: begin
                if (!ar_pend_q) state_d = CMD;
            end
            default: state_d = IDLE;
        endcase

        // Timer runs in every busy state except RETRY and overrides the normal flow.
        if ((state_q == CMD) || cap_en) begin
            if (!full && (tmo_q >= TMO_W'(TIMEOUT - 1))) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        cmd_d = ((state_d == CMD) || (state_d == HOLD)) ? CMD_READ : CMD_NOP;
        bd_d  = (state_d == BDONE);
    end

    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cmd_q     <= CMD_NOP;
            bd_q      <= 1'b0;
            err_q     <= 1'b0;
            ar_pend_q <= 1'b0;
            tmo_q     <= '0;
            hold_q    <= '0;
            bdc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            bd_q      <= bd_d;
            err_q     <= err_d;
            ar_pend_q <= ar_pend_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            bdc_q     <= bdc_d;
        end
    end

    assign Addr_out       = addr_q;
    assign CMD_out        = cmd_q;
    assign Burst_Done_out = bd_q;
    assign Err_out        = err_q;
    assign Busy_out       = (state_q != IDLE);

endmodule
